xcu_sequencer: RTL and testbench

XCU_SEQUENCER -- requirements
Module: xcu_sequencer

---
 rtl/xcu_sequencer_if.sv | 31 +++
 rtl/xcu_sequencer.sv | 74 +++++++
 tb/tb_xcu_sequencer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/xcu_sequencer_if.sv
// xcu_sequencer_if: decode-side inputs, shared crypto/bitmanip unit handshake and writeback outputs of the sequencer
interface xcu_sequencer_if;
  logic dec_valid;
  logic is_scalar_crypto;
  logic is_bitmanip;
  logic [19:0] crypto_instruction;
  logic [20:0] bitmanip_instruction;
  logic [4:0] rd;
  logic flush;
  logic unit_ready;
  logic unit_done;
  logic unit_start;
  logic unit_sel;
  logic [20:0] unit_op;
  logic stall;
  logic wb_valid;
  logic wb_we;
  logic [4:0] wb_rd;
  logic err_timeout;
  logic [15:0] op_count;
  modport master (
    output dec_valid, is_scalar_crypto, is_bitmanip, crypto_instruction, bitmanip_instruction,
    output rd, flush, unit_ready, unit_done,
    input unit_start, unit_sel, unit_op, stall, wb_valid, wb_we, wb_rd, err_timeout, op_count
  );
  modport slave (
    input dec_valid, is_scalar_crypto, is_bitmanip, crypto_instruction, bitmanip_instruction,
    input rd, flush, unit_ready, unit_done,
    output unit_start, unit_sel, unit_op, stall, wb_valid, wb_we, wb_rd, err_timeout, op_count
  );
endinterface

// File: rtl/xcu_sequencer.sv
// xcu_sequencer: issues one scalar-crypto/bitmanip op at a time to a shared unit, stalls decode and strobes writeback
module xcu_sequencer #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic clk,
  input logic rst,
  xcu_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT_RDY, RUN, WB} state_t;
  state_t r_state, w_next;
  logic [3:0] r_cnt, w_inc;
  logic [15:0] r_ops;
  logic [20:0] r_op, w_op;
  logic [4:0] r_rd;
  logic r_sel, w_sel, w_accept, w_tmo;
  assign w_sel = !bus.is_scalar_crypto;
  assign w_op = w_sel ? bus.bitmanip_instruction : {1'b0, bus.crypto_instruction};
  assign w_accept = !rst && r_state == IDLE && bus.dec_valid && (bus.is_scalar_crypto || bus.is_bitmanip) && |w_op && !bus.flush;
  // w_inc is the RUN cycle count including the current cycle
  assign w_inc = &r_cnt ? r_cnt : r_cnt + 4'd1;
  assign w_tmo = w_inc == 4'(TIMEOUT);
  always_comb begin
    w_next = r_state;
    bus.unit_start = 1'b0;
    bus.wb_valid = 1'b0;
    bus.err_timeout = 1'b0;
    bus.stall = 1'b0;
    if (!rst)
      case (r_state)
        IDLE: if (w_accept) begin
          bus.stall = 1'b1;
          bus.unit_start = bus.unit_ready;
          w_next = bus.unit_ready ? RUN : WAIT_RDY;
        end
        WAIT_RDY: begin
          bus.stall = 1'b1;
          bus.unit_start = !bus.flush && bus.unit_ready;
          w_next = bus.flush ? IDLE : bus.unit_ready ? RUN : WAIT_RDY;
        end
        RUN: begin
          bus.stall = 1'b1;
          bus.err_timeout = !bus.flush && !bus.unit_done && w_tmo;
          w_next = bus.flush ? IDLE : bus.unit_done ? WB : w_tmo ? IDLE : RUN;
        end
        WB: begin
          bus.wb_valid = !bus.flush;
          w_next = IDLE;
        end
      endcase
  end
  assign bus.wb_we = bus.wb_valid && |r_rd;
  assign bus.unit_sel = w_accept ? w_sel : r_sel;
  assign bus.unit_op = w_accept ? w_op : r_op;
  assign bus.wb_rd = r_rd;
  assign bus.op_count = r_ops;
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= 4'd0;
      r_ops <= 16'd0;
      r_op <= 21'd0;
      r_sel <= 1'b0;
      r_rd <= 5'd0;
    end else begin
      r_state <= w_next;
      r_cnt <= r_state == RUN ? w_inc : 4'd0;
      if (bus.wb_valid) r_ops <= r_ops + 16'd1;
      if (w_accept) begin
        r_op <= w_op;
        r_sel <= w_sel;
        r_rd <= bus.rd;
      end
    end
endmodule

// File: tb/tb_xcu_sequencer.sv
// tb_xcu_sequencer: vector table of single ops plus hand sequences for flush/reset/back-to-back; results checked through a queue
module tb_xcu_sequencer;
  localparam int TMO = 3;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  xcu_sequencer_if bus();
  xcu_sequencer #(.TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic dv, c, b;
    logic [19:0] cv;
    logic [20:0] bv;
    logic [4:0] rd;
    int rw, da, fa;
    logic acc, sel;
    logic [20:0] op;
    logic wb, tmo;
  } vec_t;
  typedef struct {
    logic tmo;
    logic [4:0] rd;
    logic we;
    logic [15:0] ops;
  } exp_t;
  exp_t q[$];
  exp_t e;
  vec_t vt[12];
  int errors = 0;
  int checks = 0;
  logic [15:0] m_ops = 16'd0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, x);
    end
  endtask
  task automatic drive0();
    bus.dec_valid = 1'b0;
    bus.is_scalar_crypto = 1'b0;
    bus.is_bitmanip = 1'b0;
    bus.crypto_instruction = 20'd0;
    bus.bitmanip_instruction = 21'd0;
    bus.rd = 5'd0;
    bus.flush = 1'b0;
    bus.unit_ready = 1'b0;
    bus.unit_done = 1'b0;
  endtask
  task automatic drive_op(input logic c, input logic b, input logic [19:0] cv, input logic [20:0] bv, input logic [4:0] rd, input logic rdy);
    drive0();
    bus.dec_valid = 1'b1;
    bus.is_scalar_crypto = c;
    bus.is_bitmanip = b;
    bus.crypto_instruction = cv;
    bus.bitmanip_instruction = bv;
    bus.rd = rd;
    bus.unit_ready = rdy;
  endtask
  always @(negedge clk) begin
    #2;
    if (bus.wb_valid || bus.err_timeout) begin
      if (q.size() == 0) chk("unexpected_result", {bus.wb_valid, bus.err_timeout}, 0);
      else begin
        e = q.pop_front();
        chk("result_kind", {bus.err_timeout, bus.wb_valid}, e.tmo ? 2'b10 : 2'b01);
        if (!e.tmo) begin
          chk("wb_rd", bus.wb_rd, e.rd);
          chk("wb_we", bus.wb_we, e.we);
          chk("wb_op_count", bus.op_count, e.ops);
        end
      end
    end
  end
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    drive_op(v.c, v.b, v.cv, v.bv, v.rd, v.rw == 0);
    bus.dec_valid = v.dv;
    #1;
    chk("acc_stall", bus.stall, v.acc);
    chk("acc_start", bus.unit_start, v.acc && v.rw == 0);
    if (!v.acc) begin
      @(negedge clk);
      drive0();
      #1;
      chk("noacc_stall", bus.stall, 0);
      return;
    end
    chk("acc_sel", bus.unit_sel, v.sel);
    chk("acc_op", bus.unit_op, v.op);
    if (v.wb) begin
      q.push_back('{1'b0, v.rd, v.rd != 5'd0, m_ops});
      m_ops++;
    end else if (v.tmo) q.push_back('{1'b1, 5'd0, 1'b0, m_ops});
    for (int i = 1; i <= v.rw; i++) begin
      @(negedge clk);
      drive_op(1'b0, 1'b1, 20'd0, 21'h3, 5'd17, i == v.rw);
      #1;
      chk("wait_stall", bus.stall, 1);
      chk("wait_start", bus.unit_start, i == v.rw);
      chk("wait_op", bus.unit_op, v.op);
      chk("wait_sel", bus.unit_sel, v.sel);
    end
    for (int r = 1; r <= 8; r++) begin
      @(negedge clk);
      drive0();
      bus.unit_ready = 1'b1;
      bus.unit_done = r == v.da;
      bus.flush = r == v.fa;
      #1;
      chk("run_stall", bus.stall, 1);
      chk("run_start", bus.unit_start, 0);
      chk("run_op", bus.unit_op, v.op);
      chk("run_tmo", bus.err_timeout, r == TMO && r != v.da && r != v.fa);
      if (r == v.da || r == v.fa || r == TMO) break;
    end
    @(negedge clk);
    drive0();
    #1;
    chk("post_stall", bus.stall, 0);
    chk("post_wb", bus.wb_valid, v.wb);
    @(negedge clk);
    #1;
    chk("post_op_count", bus.op_count, m_ops);
    chk("queue_empty", q.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vt[0]  = '{1, 1, 0, 20'h00100, 21'h0, 5'd5, 0, 3, 0, 1, 0, 21'h000100, 1, 0};
    vt[1]  = '{1, 0, 1, 20'h0, 21'h000400, 5'd0, 2, 2, 0, 1, 1, 21'h000400, 1, 0};
    vt[2]  = '{1, 1, 0, 20'h00002, 21'h0, 5'd7, 0, 0, 0, 1, 0, 21'h000002, 0, 1};
    vt[3]  = '{1, 1, 0, 20'h08000, 21'h0, 5'd9, 0, 2, 2, 1, 0, 21'h008000, 0, 0};
    vt[4]  = '{1, 1, 1, 20'h00001, 21'h000010, 5'd3, 0, 1, 0, 1, 0, 21'h000001, 1, 0};
    vt[5]  = '{1, 1, 1, 20'h0, 21'h000010, 5'd3, 0, 1, 0, 0, 0, 21'h0, 0, 0};
    vt[6]  = '{1, 0, 1, 20'h00004, 21'h0, 5'd3, 0, 1, 0, 0, 0, 21'h0, 0, 0};
    vt[7]  = '{0, 1, 0, 20'h00004, 21'h0, 5'd3, 0, 1, 0, 0, 0, 21'h0, 0, 0};
    vt[8]  = '{1, 0, 1, 20'h0, 21'h100000, 5'd31, 1, 1, 0, 1, 1, 21'h100000, 1, 0};
    vt[9]  = '{1, 1, 0, 20'h80000, 21'h0, 5'd1, 1, 0, 0, 1, 0, 21'h080000, 0, 1};
    vt[10] = '{1, 0, 1, 20'h0, 21'h000001, 5'd2, 0, 0, 1, 1, 1, 21'h000001, 0, 0};
    vt[11] = '{1, 0, 0, 20'h00004, 21'h000004, 5'd3, 0, 1, 0, 0, 0, 21'h0, 0, 0};
    rst = 1'b1;
    drive0();
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive_op(1'b1, 1'b0, 20'h1, 21'h0, 5'd4, 1'b1);
    #1;
    chk("rst_stall", bus.stall, 0);
    chk("rst_start", bus.unit_start, 0);
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_err", bus.err_timeout, 0);
    @(negedge clk);
    rst = 1'b0;
    drive0();
    #1;
    chk("rst_unit_op", bus.unit_op, 0);
    chk("rst_unit_sel", bus.unit_sel, 0);
    chk("rst_wb_rd", bus.wb_rd, 0);
    chk("rst_op_count", bus.op_count, 0);
    for (int i = 0; i < 12; i++) run_vec(vt[i]);
    // flush in IDLE blocks accept
    @(negedge clk);
    drive_op(1'b1, 1'b0, 20'h1, 21'h0, 5'd4, 1'b1);
    bus.flush = 1'b1;
    #1;
    chk("idle_flush_stall", bus.stall, 0);
    chk("idle_flush_start", bus.unit_start, 0);
    @(negedge clk);
    drive0();
    #1;
    chk("idle_flush_after", bus.stall, 0);
    // flush in WAIT_RDY beats unit_ready
    @(negedge clk);
    drive_op(1'b1, 1'b0, 20'h1, 21'h0, 5'd4, 1'b0);
    #1;
    chk("wflush_acc", bus.stall, 1);
    @(negedge clk);
    drive0();
    bus.flush = 1'b1;
    bus.unit_ready = 1'b1;
    #1;
    chk("wflush_start", bus.unit_start, 0);
    chk("wflush_stall", bus.stall, 1);
    @(negedge clk);
    drive0();
    #1;
    chk("wflush_after", bus.stall, 0);
    // flush in WB suppresses writeback
    @(negedge clk);
    drive_op(1'b1, 1'b0, 20'h1, 21'h0, 5'd4, 1'b1);
    #1;
    chk("bflush_start", bus.unit_start, 1);
    @(negedge clk);
    drive0();
    bus.unit_done = 1'b1;
    @(negedge clk);
    drive0();
    bus.flush = 1'b1;
    #1;
    chk("bflush_wb", bus.wb_valid, 0);
    chk("bflush_we", bus.wb_we, 0);
    @(negedge clk);
    drive0();
    #1;
    chk("bflush_ops", bus.op_count, m_ops);
    chk("bflush_stall", bus.stall, 0);
    // no accept in WB; next op taken in the following IDLE cycle
    @(negedge clk);
    drive_op(1'b0, 1'b1, 20'h0, 21'h000020, 5'd6, 1'b1);
    #1;
    chk("b2b_start1", bus.unit_start, 1);
    q.push_back('{1'b0, 5'd6, 1'b1, m_ops});
    m_ops++;
    @(negedge clk);
    drive0();
    bus.unit_done = 1'b1;
    @(negedge clk);
    drive_op(1'b1, 1'b0, 20'h00040, 21'h0, 5'd8, 1'b1);
    #1;
    chk("b2b_wb_stall", bus.stall, 0);
    chk("b2b_wb_start", bus.unit_start, 0);
    @(negedge clk);
    #1;
    chk("b2b_idle_stall", bus.stall, 1);
    chk("b2b_idle_start", bus.unit_start, 1);
    chk("b2b_idle_op", bus.unit_op, 21'h000040);
    q.push_back('{1'b0, 5'd8, 1'b1, m_ops});
    m_ops++;
    @(negedge clk);
    drive0();
    bus.unit_done = 1'b1;
    @(negedge clk);
    drive0();
    @(negedge clk);
    #1;
    chk("b2b_ops", bus.op_count, m_ops);
    chk("b2b_queue", q.size(), 0);
    // reset mid-RUN, later unit_done ignored
    @(negedge clk);
    drive_op(1'b1, 1'b0, 20'h2, 21'h0, 5'd10, 1'b1);
    @(negedge clk);
    drive0();
    @(negedge clk);
    rst = 1'b1;
    bus.unit_done = 1'b1;
    #1;
    chk("rrun_start", bus.unit_start, 0);
    chk("rrun_stall", bus.stall, 0);
    chk("rrun_wb", bus.wb_valid, 0);
    chk("rrun_err", bus.err_timeout, 0);
    @(negedge clk);
    rst = 1'b0;
    drive0();
    m_ops = 16'd0;
    #1;
    chk("rrun_ops", bus.op_count, 0);
    chk("rrun_idle", bus.stall, 0);
    chk("rrun_unit_op", bus.unit_op, 0);
    @(negedge clk);
    bus.unit_done = 1'b1;
    #1;
    chk("late_done_stall", bus.stall, 0);
    @(negedge clk);
    drive0();
    #1;
    chk("late_done_ops", bus.op_count, m_ops);
    chk("late_done_queue", q.size(), 0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
